// File: rtl/simon2share_loader_if.sv
// Job, serial-load and core-result signals between a host, the share loader and the masked Simon core.
// The loader connects through the slave modport; the host/core environment uses master.
interface simon2share_loader_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key_a;
    logic [127:0] key_b;
    logic [127:0] pt_a;
    logic [127:0] pt_b;
    logic         data_ina;
    logic         data_inb;
    logic [1:0]   data_rdy;
    logic         core_done;
    logic [127:0] core_cipher;
    logic         out_valid;
    logic [127:0] cipher_out;
    logic         timeout_err;

    modport master (
        output in_valid, key_a, key_b, pt_a, pt_b, core_done, core_cipher,
        input  in_ready, data_ina, data_inb, data_rdy, out_valid, cipher_out, timeout_err
    );

    modport slave (
        input  in_valid, key_a, key_b, pt_a, pt_b, core_done, core_cipher,
        output in_ready, data_ina, data_inb, data_rdy, out_valid, cipher_out, timeout_err
    );
endinterface

// File: rtl/simon2share_loader.sv
// Serialises two-share key and plaintext into simon2share, then waits for Done and captures the ciphertext.
// state | meaning: IDLE accept job | KEY shift key bits | PT shift plaintext bits | RUN core busy | DONE result pulse
module simon2share_loader #(
    parameter logic [15:0] TIMEOUT = 16'd0
) (
    input logic                 clk,
    input logic                 rst_n,
    simon2share_loader_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_KEY  = 3'd1;
    localparam logic [2:0] S_PT   = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [6:0]   bit_cnt_q, bit_cnt_d;
    logic [15:0]  run_cnt_q, run_cnt_d;
    // Share a and share b live in separate shifters and are never combined here.
    logic [254:0] sh_a_q, sh_a_d;
    logic [254:0] sh_b_q, sh_b_d;
    logic         ina_q, ina_d;
    logic         inb_q, inb_d;
    logic [1:0]   rdy_q, rdy_d;
    logic         out_valid_q, out_valid_d;
    logic         timeout_err_q, timeout_err_d;
    logic [127:0] cipher_q, cipher_d;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        run_cnt_d     = run_cnt_q;
        sh_a_d        = sh_a_q;
        sh_b_d        = sh_b_q;
        ina_d         = ina_q;
        inb_d         = inb_q;
        rdy_d         = rdy_q;
        out_valid_d   = 1'b0;
        timeout_err_d = 1'b0;
        cipher_d      = cipher_q;

        case (state_q)
            S_IDLE: begin
                rdy_d = 2'b00;
                ina_d = 1'b0;
                inb_d = 1'b0;
                if (bus.in_valid) begin
                    // Bit 0 of the key goes straight to the output register; the rest queue behind it.
                    state_d   = S_KEY;
                    bit_cnt_d = 7'd0;
                    sh_a_d    = {bus.pt_a, bus.key_a[127:1]};
                    sh_b_d    = {bus.pt_b, bus.key_b[127:1]};
                    ina_d     = bus.key_a[0];
                    inb_d     = bus.key_b[0];
                    rdy_d     = 2'b10;
                end
            end
            S_KEY, S_PT: begin
                ina_d     = sh_a_q[0];
                inb_d     = sh_b_q[0];
                sh_a_d    = {1'b0, sh_a_q[254:1]};
                sh_b_d    = {1'b0, sh_b_q[254:1]};
                bit_cnt_d = bit_cnt_q + 7'd1;
                if (bit_cnt_q == 7'd127) begin
                    if (state_q == S_KEY) begin
                        state_d = S_PT;
                        rdy_d   = 2'b01;
                    end else begin
                        state_d   = S_RUN;
                        rdy_d     = 2'b11;
                        ina_d     = 1'b0;
                        inb_d     = 1'b0;
                        run_cnt_d = TIMEOUT - 16'd1;
                    end
                end
            end
            S_RUN: begin
                if (bus.core_done) begin
                    state_d     = S_DONE;
                    cipher_d    = bus.core_cipher;
                    out_valid_d = 1'b1;
                    rdy_d       = 2'b00;
                end else if ((TIMEOUT != 16'd0) && (run_cnt_q == 16'd0)) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                    rdy_d         = 2'b00;
                end else begin
                    run_cnt_d = run_cnt_q - 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                rdy_d   = 2'b00;
            end
            default: begin
                state_d = S_IDLE;
                rdy_d   = 2'b00;
                ina_d   = 1'b0;
                inb_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= 7'd0;
            run_cnt_q     <= 16'd0;
            sh_a_q        <= '0;
            sh_b_q        <= '0;
            ina_q         <= 1'b0;
            inb_q         <= 1'b0;
            rdy_q         <= 2'b00;
            out_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            cipher_q      <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            run_cnt_q     <= run_cnt_d;
            sh_a_q        <= sh_a_d;
            sh_b_q        <= sh_b_d;
            ina_q         <= ina_d;
            inb_q         <= inb_d;
            rdy_q         <= rdy_d;
            out_valid_q   <= out_valid_d;
            timeout_err_q <= timeout_err_d;
            cipher_q      <= cipher_d;
        end
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.data_ina    = ina_q;
    assign bus.data_inb    = inb_q;
    assign bus.data_rdy    = rdy_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.cipher_out  = cipher_q;
endmodule

// File: tb/tb_simon2share_loader.sv
// Directed bench for simon2share_loader with a Simon128/128 core model and a ciphertext scoreboard.
module tb_simon2share_loader;
    localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] KAT_PT  = 128'h63736564207372656c6c657661727420;
    localparam logic [127:0] KAT_CT  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [127:0] exp_q[$];

    simon2share_loader_if bus();

    simon2share_loader #(.TIMEOUT(16'd100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] simon_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [63:0] k [0:67];
        logic [63:0] x, y, t;
        logic [61:0] z;
        z    = 62'b10101111011100000011010010011000101000010001111110010110110011;
        k[0] = key[63:0];
        k[1] = key[127:64];
        for (int i = 2; i < 68; i++) begin
            t    = {k[i-1][2:0], k[i-1][63:3]};
            t    = t ^ {t[0], t[63:1]};
            k[i] = ~k[i-2] ^ t ^ {63'd0, z[61 - ((i - 2) % 62)]} ^ 64'd3;
        end
        x = pt[127:64];
        y = pt[63:0];
        for (int i = 0; i < 68; i++) begin
            t = x;
            x = y ^ ({x[62:0], x[63]} & {x[55:0], x[63:56]}) ^ {x[61:0], x[63:62]} ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts just after a falling edge with the DUT idle; returns just after a falling edge with it idle.
    task automatic run_job(input logic [127:0] ka, input logic [127:0] kb,
                           input logic [127:0] pa, input logic [127:0] pb,
                           input int delay, input bit hold, input int stray_at,
                           input int rst_at, input bit kat);
        logic [255:0] rec_a, rec_b;
        logic [127:0] prev_cipher, cc, expc;
        int bad;
        check("idle_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.key_a = ka; bus.key_b = kb; bus.pt_a = pa; bus.pt_b = pb;
        if (delay >= 0 && rst_at < 0)
            exp_q.push_back(kat ? KAT_CT : simon_enc(ka ^ kb, pa ^ pb));
        prev_cipher = bus.cipher_out;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (!hold) bus.in_valid = 1'b0;
                bus.key_a = rand128(); bus.key_b = rand128();
                bus.pt_a = rand128();  bus.pt_b = rand128();
            end
            if (bus.data_rdy !== (i < 128 ? 2'b10 : 2'b01) || bus.in_ready !== 1'b0 ||
                bus.out_valid !== 1'b0 || bus.timeout_err !== 1'b0)
                bad++;
            rec_a[i] = bus.data_ina;
            rec_b[i] = bus.data_inb;
            bus.core_done   = (i == stray_at);
            bus.core_cipher = rand128();
            if (i == rst_at) begin
                check("seq_pre_rst", bad, 0);
                rst_n = 1'b0;
                #1;
                check("rst_rdy", bus.data_rdy, 2'b00);
                check("rst_ready", bus.in_ready, 1'b1);
                check("rst_cipher", bus.cipher_out, 128'd0);
                @(negedge clk);
                rst_n = 1'b1;
                bad = 0;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.data_rdy !== 2'b00) bad++;
                end
                check("post_rst_idle", bad, 0);
                return;
            end
        end
        check("seq_key_pt", bad, 0);
        check("ser_a", rec_a, {pa, ka});
        check("ser_b", rec_b, {pb, kb});
        cc  = simon_enc(rec_a[127:0] ^ rec_b[127:0], rec_a[255:128] ^ rec_b[255:128]);
        bad = 0;
        if (delay < 0) begin
            for (int j = 0; j < 100; j++) begin
                @(negedge clk);
                if (j == 0) check("run_entry", {bus.data_rdy, bus.data_ina, bus.data_inb}, 4'b1100);
                if (bus.data_rdy !== 2'b11 || bus.timeout_err !== 1'b0 || bus.in_ready !== 1'b0) bad++;
            end
            @(negedge clk);
            check("tmo_pulse", bus.timeout_err, 1'b1);
            check("tmo_state", {bus.data_rdy, bus.in_ready, bus.out_valid}, 4'b0010);
            check("tmo_cipher", bus.cipher_out, prev_cipher);
            @(negedge clk);
            check("tmo_clear", {bus.timeout_err, bus.in_ready}, 2'b01);
            check("run_hold", bad, 0);
            return;
        end
        for (int j = 0; j <= delay; j++) begin
            @(negedge clk);
            if (j == 0) check("run_entry", {bus.data_rdy, bus.data_ina, bus.data_inb}, 4'b1100);
            if (bus.data_rdy !== 2'b11 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) bad++;
            if (j == delay) begin
                bus.core_done   = 1'b1;
                bus.core_cipher = cc;
            end
        end
        check("run_hold", bad, 0);
        @(negedge clk);
        bus.core_done   = 1'b0;
        bus.core_cipher = rand128();
        expc = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("done_state", {bus.out_valid, bus.data_rdy, bus.in_ready}, 4'b1000);
        check("cipher", bus.cipher_out, expc);
        @(negedge clk);
        check("after_done", {bus.out_valid, bus.in_ready}, 2'b01);
    endtask

    initial begin
        logic [127:0] m1, m2;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.key_a = '0; bus.key_b = '0; bus.pt_a = '0; bus.pt_b = '0;
        bus.core_done = 1'b0;
        bus.core_cipher = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.in_ready, 1'b1);
        check("rst_rdy", bus.data_rdy, 2'b00);
        check("rst_ser", {bus.data_ina, bus.data_inb}, 2'b00);
        check("rst_pulses", {bus.out_valid, bus.timeout_err}, 2'b00);
        check("rst_cipher", bus.cipher_out, 128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_stay", {bus.in_ready, bus.data_rdy}, 3'b100);

        m1 = rand128();
        m2 = rand128();
        run_job(KAT_KEY ^ m1, m1, KAT_PT ^ m2, m2, 5, 1'b0, -1, -1, 1'b1);
        run_job('0, '0, 128'd1, '0, 0, 1'b0, -1, -1, 1'b0);
        run_job(rand128(), rand128(), rand128(), rand128(), 3, 1'b1, -1, -1, 1'b0);
        run_job(rand128(), rand128(), rand128(), rand128(), 7, 1'b0, -1, -1, 1'b0);
        run_job(rand128(), rand128(), rand128(), rand128(), 5, 1'b0, -1, 128 + 60, 1'b0);
        run_job(rand128(), rand128(), rand128(), rand128(), 10, 1'b0, -1, -1, 1'b0);
        run_job(rand128(), rand128(), rand128(), rand128(), 20, 1'b0, 10, -1, 1'b0);
        run_job(rand128(), rand128(), rand128(), rand128(), -1, 1'b0, -1, -1, 1'b0);
        run_job(rand128(), rand128(), rand128(), rand128(), 98, 1'b0, -1, -1, 1'b0);

        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/simon2share_loader.md
SIMON2SHARE_LOADER -- requirements
Module: simon2share_loader

Interface
REQ-001 Parameter: TIMEOUT, default 16'd0, max cycles in RUN before abort; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  job request; key/plaintext share buses valid while high.
REQ-005 in_ready  output  1  loader can accept a job.
REQ-006 key_a, key_b  input  128 each  two Boolean shares of the key; key = key_a ^ key_b.
REQ-007 pt_a, pt_b  input  128 each  two Boolean shares of the plaintext.
REQ-008 data_ina, data_inb  output  1 each  serial share bits to simon2share.
REQ-009 data_rdy  output  2  core load code: 00 idle, 10 key bits, 01 plaintext bits, 11 run.
REQ-010 core_done  input  1  Done from simon2share.
REQ-011 core_cipher  input  128  cipher_out from simon2share.
REQ-012 out_valid  output  1  one-cycle pulse; cipher_out holds the result.
REQ-013 cipher_out  output  128  captured ciphertext.
REQ-014 timeout_err  output  1  one-cycle pulse when a RUN aborts on timeout.

Function
REQ-015 FSM states: IDLE, KEY, PT, RUN, DONE; encoding is free.
REQ-016 IDLE: in_ready=1, data_rdy=00, data_ina=data_inb=0.
REQ-017 Acceptance: in_valid & in_ready at edge N registers all four 128-bit buses into internal shift registers and enters KEY at N+1; in_ready drops at N+1.
REQ-018 KEY: 128 cycles; data_rdy=10; cycle k (0..127) drives data_ina=key_a[k], data_inb=key_b[k], LSB first.
REQ-019 PT: follows KEY directly with no gap; 128 cycles; data_rdy=01; cycle k drives pt_a[k], pt_b[k], LSB first.
REQ-020 Bit counter: 7 bits; 127 wraps to 0 on the KEY->PT and PT->RUN transitions.
REQ-021 RUN: data_rdy=11 held and data_ina=data_inb=0 until core_done is sampled high.
REQ-022 core_done high in RUN: capture core_cipher into cipher_out on the same edge; go to DONE.
REQ-023 DONE: lasts one cycle; out_valid=1, data_rdy=00; then IDLE.
REQ-024 core_done is ignored in every state other than RUN.
REQ-025 in_valid is ignored outside IDLE; input buses may change freely after acceptance.
REQ-026 Timeout (TIMEOUT!=0): RUN cycle counter reaches TIMEOUT without core_done -> timeout_err pulse, data_rdy=00, IDLE; cipher_out unchanged.
REQ-027 Total latency: acceptance to first RUN cycle is 256 cycles + 1.
REQ-028 All outputs are registered; no combinational path from input to output, except in_ready, which is decoded from state.
REQ-029 The shares are never XORed together inside the block; share a and share b use separate registers.

Reset
REQ-030 While rst_n is low, state returns to IDLE immediately and asynchronously.
REQ-031 Reset values: in_ready=1, data_rdy=00, data_ina=data_inb=0, out_valid=0, timeout_err=0, cipher_out=0, counters=0.
REQ-032 Reset mid-KEY/PT/RUN abandons the job; no out_valid is produced; the first post-reset edge stays in IDLE unless in_valid is high.
REQ-033 Shift-register contents are don't-care after reset; they are reloaded at the next acceptance.

Verification
REQ-034 Known-answer test: key 0f0e0d0c0b0a09080706050403020100 and pt 63736564207372656c6c657661727420, each masked with random share b, plus a core model -> data_rdy=10 for 128 cycles, then 01 for 128, then 11; out_valid with cipher_out = the Simon128/128 vector.
REQ-035 Serial check: pt_a=1, all other shares 0 -> data_ina=1 only on PT cycle 0; data_inb=0 on all 256 cycles.
REQ-036 Back-to-back jobs: in_valid held high -> second job accepted on the cycle after DONE; in_ready=0 on every cycle from KEY through DONE.
REQ-037 Reset at PT cycle 60 -> data_rdy=00 immediately; no out_valid; a new job then completes normally.
REQ-038 TIMEOUT=100 with core_done held low -> timeout_err on the cycle after 100 RUN cycles; then IDLE with in_ready=1.
REQ-039 core_done pulsed during KEY -> ignored; job completes normally on the later core_done in RUN.
